fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DW, default 9: data word width, matching the 16x9 FIFO.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock, the AXI clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  0 = no new grants are issued; a transfer in flight completes.
REQ-007 prio_mode  in  1  0 = round-robin; 1 = fixed priority, with index 0 highest.
REQ-008 req  in  NREQ  per-requester write request, held until acknowledged.
REQ-009 req_data  in  NREQ*DW  per-requester word; requester i uses bits [i*DW +: DW].
REQ-010 ack  out  NREQ  one-cycle acknowledge, one-hot or zero.
REQ-011 fifo_full  in  1  full flag from the FIFO.
REQ-012 fifo_wr_request  out  1  one-cycle FIFO write strobe.
REQ-013 fifo_wr_data  out  DW  word presented to the FIFO.
REQ-014 grant_id  out  clog2(NREQ)  index of the current or last winner.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, WRITE and GAP.
REQ-017 IDLE -> WRITE when enable=1, fifo_full=0 and req is nonzero; otherwise the FSM stays in IDLE.
REQ-018 On the IDLE->WRITE edge, the block SHALL register the winner index into grant_id and the winner's word into fifo_wr_data.
REQ-019 WRITE: fifo_wr_request=1 and ack[grant_id]=1 for exactly one cycle; the next state is GAP unconditionally.
REQ-020 GAP: one idle cycle, so the FIFO indices, the full flag and the requester's req drop can settle; the next state is IDLE.
REQ-021 Peak throughput SHALL be one word per 3 cycles; latency from req seen in IDLE to ack SHALL be 1 cycle.
REQ-022 Round-robin: search starts at rr_ptr and wraps modulo NREQ; the first set req wins.
REQ-023 rr_ptr SHALL update to (winner+1) mod NREQ at the WRITE->GAP edge, wrapping NREQ-1 -> 0.
REQ-024 Fixed priority: the lowest set index wins; rr_ptr is not updated in this mode.
REQ-025 A prio_mode change SHALL take effect at the next IDLE arbitration only.
REQ-026 Requester protocol: req and data stay stable until ack; req is deasserted the cycle after ack, otherwise it counts as a new request.
REQ-027 When fifo_full=1 in IDLE, no grant, ack or write strobe SHALL occur; the word is never dropped.
REQ-028 fifo_full rising during WRITE SHALL NOT abort that write; the FIFO's overflow logic owns that case.
REQ-029 enable falling during WRITE or GAP SHALL let the sequence finish, then hold in IDLE.
REQ-030 Simultaneous requests SHALL produce exactly one grant per arbitration; losers hold and are served in later rounds.
REQ-031 fifo_wr_data SHALL hold its value outside WRITE.

Reset
REQ-032 Reset SHALL immediately (asynchronously) force: state=IDLE, rr_ptr=0, grant_id=0, ack=0, fifo_wr_request=0, fifo_wr_data=0, busy=0.
REQ-033 Reset asserted during WRITE SHALL drop the strobe and ack at once; no partial write is retried after release.
REQ-034 The first arbitration SHALL occur on the first clock edge after reset deasserts.

Structure
REQ-035 The FSM state enum, the DW default and the NREQ default SHALL live in the shared serial package.
REQ-036 One sub-module, rr_pick, SHALL provide combinational one-hot selection from req, rr_ptr and prio_mode, yielding the winner index and a valid flag.
REQ-037 The top level SHALL drive the FIFO write port directly, without the write-request edge detector.

Verification
REQ-038 Single request: req=4'b0100, data2=9'h1A5 -> ack=4'b0100 one cycle after IDLE; fifo_wr_request one cycle with fifo_wr_data=9'h1A5; grant_id=2.
REQ-039 Round-robin fairness: req=4'b1111 held, each re-raised after ack -> grant order 0,1,2,3,0; writes 3 cycles apart.
REQ-040 Fixed priority: prio_mode=1, req=4'b1010 -> requester 1 granted repeatedly while it re-requests; requester 3 only after req[1] drops.
REQ-041 Backpressure: fifo_full=1 with req=4'b0001 for 10 cycles -> no ack, no strobe; fifo_full->0 -> ack on the next IDLE cycle.
REQ-042 Reset mid-WRITE: reset pulse in the WRITE cycle -> ack and fifo_wr_request go 0 asynchronously; after release rr_ptr=0 and the next grant goes to the lowest pending index.
REQ-043 Enable gating: enable=0 with req=4'b0011 -> busy=0, no grant; enable=1 -> requester 0 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared defaults and FSM state type for the FIFO write arbiter
package fifo_wr_arbiter_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int DW_DEFAULT   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin / fixed-priority winner select
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    input  logic            prio_mode,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [IW-1:0] start;
    logic [IW:0]   idx;

    // Walk the search order backwards so the earliest hit is the last one written.
    always_comb begin
        onehot = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        start  = prio_mode ? '0 : rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, start} + (IW + 1)'(k);
            if (idx >= (IW + 1)'(NREQ)) begin
                idx = idx - (IW + 1)'(NREQ);
            end
            if (req[idx[IW-1:0]]) begin
                winner = idx[IW-1:0];
                valid  = 1'b1;
            end
        end
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - arbitrates NREQ requesters onto one FIFO write port, one word per 3 cycles
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int DW   = DW_DEFAULT,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               prio_mode,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    input  logic               fifo_full,
    output logic               fifo_wr_request,
    output logic [DW-1:0]      fifo_wr_data,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);

    arb_state_t      state;
    arb_state_t      next_state;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] grant_onehot;
    logic            grant_rr;
    logic            arb_go;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_winner;
    logic            pick_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .prio_mode (prio_mode),
        .onehot    (pick_onehot),
        .winner    (pick_winner),
        .valid     (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobe and ack decode straight from state so reset removes them asynchronously.
    always_comb begin
        next_state      = state;
        arb_go          = 1'b0;
        ack             = '0;
        fifo_wr_request = 1'b0;
        busy            = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (enable && !fifo_full && pick_valid) begin
                    next_state = ST_WRITE;
                    arb_go     = 1'b1;
                end
            end
            ST_WRITE: begin
                fifo_wr_request = 1'b1;
                ack             = grant_onehot;
                next_state      = ST_GAP;
            end
            ST_GAP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id     <= '0;
            grant_onehot <= '0;
            grant_rr     <= 1'b0;
            fifo_wr_data <= '0;
            rr_ptr       <= '0;
        end else begin
            if (arb_go) begin
                grant_id     <= pick_winner;
                grant_onehot <= pick_onehot;
                grant_rr     <= ~prio_mode;
                fifo_wr_data <= req_data[pick_winner*DW +: DW];
            end
            // The pointer only moves for grants that were won under round-robin.
            if (state == ST_WRITE && grant_rr) begin
                rr_ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

endmodule
